// File: rtl/txwregif_rdctl.sv
// TX write-register-interface FIFO reader: pops 3-word records (addr, data hi, data lo)
// and issues one req/ack register write per record. Optional ack timeout: TXWREGIF_TIMEOUT_EN.
module txwregif_rdctl #(
    parameter int WIDTH   = 16,
    parameter int PTR     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_rdempty,
    input  logic [WIDTH-1:0] fifo_dataout,
    input  logic [PTR:0]     fifo_rdusedw,
    output logic             fifo_rden,
    output logic             reg_wr,
    output logic [15:0]      reg_addr,
    output logic [31:0]      reg_wdata,
    input  logic             reg_ack,
    output logic             wr_done,
    output logic [15:0]      wr_cnt,
    output logic             busy,
    output logic             err,
    output logic [PTR:0]     dbg_fill
);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

    state_t     state, state_nx;
    logic       rd_pend;
    logic [1:0] wcnt;
    logic       to_hit;

`ifdef TXWREGIF_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] to_cnt;

    // an ack on the limit cycle takes priority over the abort
    assign to_hit = reg_wr && !reg_ack && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            err <= to_hit;
            if (state != WRITE)
                to_cnt <= '0;
            else if (!reg_ack)
                to_cnt <= to_cnt + 8'd1;
        end
    end
`else
    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        fifo_rden = 1'b0;
        case (state)
            IDLE:  if (!fifo_rdempty) state_nx = FETCH;
            FETCH: begin
                // one pop in flight at a time: data lands the cycle after rden
                fifo_rden = !fifo_rdempty && !rd_pend;
                if (rd_pend && wcnt == 2'd2) state_nx = WRITE;
            end
            WRITE: if ((reg_wr && reg_ack) || to_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend   <= 1'b0;
            wcnt      <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr    <= 1'b0;
            wr_done   <= 1'b0;
            wr_cnt    <= '0;
            dbg_fill  <= '0;
        end else begin
            rd_pend  <= fifo_rden;
            dbg_fill <= fifo_rdusedw;
            wr_done  <= 1'b0;

            if (state == IDLE) begin
                wcnt <= '0;
            end else if (rd_pend) begin
                case (wcnt)
                    2'd0:    reg_addr          <= fifo_dataout;
                    2'd1:    reg_wdata[31:16]  <= fifo_dataout;
                    default: reg_wdata[15:0]   <= fifo_dataout;
                endcase
                wcnt <= wcnt + 2'd1;
            end

            if (state == FETCH && state_nx == WRITE) begin
                reg_wr <= 1'b1;
            end else if (reg_wr && reg_ack) begin
                reg_wr  <= 1'b0;
                wr_done <= 1'b1;
                wr_cnt  <= wr_cnt + 16'd1;
            end else if (to_hit) begin
                reg_wr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_txwregif_rdctl.sv
// Directed bench for txwregif_rdctl: behavioural FIFO model, configurable ack responder,
// hand-computed expected values per test.
module tb_txwregif_rdctl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_rdempty = 1'b1;
    logic [15:0] fifo_dataout = '0;
    logic [2:0]  fifo_rdusedw = '0;
    logic        fifo_rden, reg_wr, wr_done, busy, err;
    logic        reg_ack = 1'b0;
    logic [15:0] reg_addr, wr_cnt;
    logic [31:0] reg_wdata;
    logic [2:0]  dbg_fill;

    txwregif_rdctl #(.WIDTH(16), .PTR(2), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .fifo_rdempty(fifo_rdempty), .fifo_dataout(fifo_dataout), .fifo_rdusedw(fifo_rdusedw),
        .fifo_rden(fifo_rden), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_ack(reg_ack), .wr_done(wr_done), .wr_cnt(wr_cnt), .busy(busy), .err(err),
        .dbg_fill(dbg_fill)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model: flags/level update at the clock edge, data valid the cycle after rden
    logic [15:0] q[$];
    int rden_cnt = 0, under = 0;
    always @(posedge clk) begin
        if (fifo_rden) begin
            rden_cnt++;
            if (fifo_rdempty) under++;
            else fifo_dataout <= q.pop_front();
        end
        fifo_rdempty <= (q.size() == 0);
        fifo_rdusedw <= 3'(q.size());
    end

    // monitor + ack responder: ack is raised on the ack_dly-th cycle of reg_wr (0 = never)
    int cyc = 0, done_cnt = 0, err_cnt = 0, hi_cnt = 0, fetch_cyc = 0, overlap = 0;
    int wcyc = 0, ack_dly = 1;
    int done_t[$];
    logic [15:0] log_a[$];
    logic [31:0] log_d[$];
    always @(posedge clk) begin
        #1;
        cyc++;
        if (reg_wr) hi_cnt++;
        if (busy && !reg_wr) fetch_cyc++;
        if (wr_done) begin done_cnt++; done_t.push_back(cyc); end
        if (err) err_cnt++;
        if (reg_wr && (wr_done || fifo_rden)) overlap++;
        if (reg_wr) begin
            wcyc++;
            reg_ack = (ack_dly != 0 && wcyc == ack_dly);
            if (reg_ack) begin log_a.push_back(reg_addr); log_d.push_back(reg_wdata); end
        end else begin
            wcyc = 0;
            reg_ack = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [15:0] w);
        int g = 0;
        while (q.size() >= 4 && g < 500) begin tick(); g++; end
        q.push_back(w);
    endtask

    task automatic wait_done(input int n, input string tag);
        int g = 0;
        while (done_cnt < n && g < 300) begin tick(); g++; end
        chk(tag, done_cnt, n);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r0, d0, h0, f0, b, la, e0, g;

        // reset state
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_ctl", {reg_wr, wr_done, busy, err, fifo_rden, dbg_fill}, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wdata", reg_wdata, 0);
        chk("rst_cnt", wr_cnt, 0);

        // single record, ack on 2nd write cycle
        ack_dly = 2; r0 = rden_cnt; d0 = done_cnt; h0 = hi_cnt; f0 = fetch_cyc; la = log_a.size();
        push(16'h0040); push(16'hDEAD); push(16'hBEEF);
        wait_done(d0 + 1, "t1_done");
        repeat (3) tick();
        chk("t1_once", done_cnt, d0 + 1);
        chk("t1_addr", log_a[la], 32'h0040);
        chk("t1_data", log_d[la], 32'hDEADBEEF);
        chk("t1_rden", rden_cnt - r0, 3);
        chk("t1_wrcyc", hi_cnt - h0, 2);
        chk("t1_fetch", fetch_cyc - f0, 6);
        chk("t1_cnt", wr_cnt, 1);

        // stalled FIFO
        r0 = rden_cnt; d0 = done_cnt; la = log_a.size();
        push(16'h0010);
        tick(); tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t2_busy", busy, 1);
        end
        chk("t2_rden", rden_cnt - r0, 1);
        chk("t2_fill0", dbg_fill, 0);
        push(16'h1234); push(16'h5678);
        tick(); tick();
        chk("t2_fill2", dbg_fill, 2);
        wait_done(d0 + 1, "t2_done");
        chk("t2_addr", log_a[la], 32'h0010);
        chk("t2_data", log_d[la], 32'h12345678);
        chk("t2_under", under, 0);

        // back-to-back, immediate ack
        ack_dly = 1; d0 = done_cnt; b = done_t.size(); la = log_a.size();
        for (int i = 0; i < 4; i++) begin
            push(16'h0100 + 16'(i)); push(16'hA000 + 16'(i)); push(16'h5000 + 16'(i));
        end
        wait_done(d0 + 4, "t3_done");
        for (int i = 0; i < 4; i++) begin
            chk("t3_addr", log_a[la + i], 32'h0100 + i);
            chk("t3_data", log_d[la + i], {16'hA000 + 16'(i), 16'h5000 + 16'(i)});
        end
        // 1 IDLE + 6 FETCH + 1 WRITE between consecutive completions
        for (int i = 0; i < 3; i++) chk("t3_gap", done_t[b + i + 1] - done_t[b + i], 8);
        chk("t3_cnt", wr_cnt, 6);
        chk("t3_ovl", overlap, 0);

        // reset after the 2nd word is captured; the word popped on the reset edge is lost
        r0 = rden_cnt; d0 = done_cnt; la = log_a.size();
        push(16'h0AAA); push(16'h1111); push(16'h2222); push(16'h3333);
        g = 0;
        while (rden_cnt - r0 < 2 && g < 100) begin tick(); g++; end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_ctl", {reg_wr, wr_done, busy, err, fifo_rden, dbg_fill}, 0);
        chk("t4_addr", reg_addr, 0);
        chk("t4_wdata", reg_wdata, 0);
        chk("t4_cnt0", wr_cnt, 0);
        chk("t4_rden", rden_cnt - r0, 3);
        push(16'h4444); push(16'h5555);
        wait_done(d0 + 1, "t4_done");
        chk("t4_addr2", log_a[la], 32'h3333);
        chk("t4_data2", log_d[la], 32'h44445555);
        chk("t4_cnt1", wr_cnt, 1);

        // counter wrap
        d0 = done_cnt;
        tick();
        force dut.wr_cnt = 16'hFFFF;
        tick();
        release dut.wr_cnt;
        tick();
        chk("t5_pre", wr_cnt, 16'hFFFF);
        push(16'h0FFF); push(16'hCAFE); push(16'hF00D);
        wait_done(d0 + 1, "t5_done");
        chk("t5_pulse", wr_done, 1);
        chk("t5_wrap", wr_cnt, 0);
        tick();
        chk("t5_pulse_end", wr_done, 0);

`ifdef TXWREGIF_TIMEOUT_EN
        // no ack: abort after 8 write cycles
        ack_dly = 0; d0 = done_cnt; h0 = hi_cnt; e0 = err_cnt;
        push(16'h0077); push(16'h1111); push(16'h2222);
        repeat (40) tick();
        chk("t6_wrcyc", hi_cnt - h0, 8);
        chk("t6_err", err_cnt - e0, 1);
        chk("t6_nodone", done_cnt, d0);
        chk("t6_cnt", wr_cnt, 0);
        // ack on the limit cycle completes normally
        ack_dly = 8; h0 = hi_cnt; la = log_a.size();
        push(16'h0078); push(16'h3333); push(16'h4444);
        wait_done(d0 + 1, "t7_done");
        repeat (2) tick();
        chk("t7_err", err_cnt - e0, 1);
        chk("t7_wrcyc", hi_cnt - h0, 8);
        chk("t7_addr", log_a[la], 32'h0078);
        chk("t7_cnt", wr_cnt, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/txwregif_rdctl.md
Name: txwregif_rdctl

Overview:
- Read-side consumer of the TX write-register-interface FIFO (16-bit wide, 4 deep, async). Runs in the FIFO's read-clock domain.
- Pops 3-word register-write records, assembles a 16-bit address and 32-bit data, and issues one register write per record to the LMAC register file.
- The register-file handshake is req/ack.

Parameters:
- WIDTH, 16, FIFO word width; must be 16.
- PTR, 2, FIFO pointer width; the FIFO usedw is PTR+1 bits.
- TIMEOUT, 255, ack-wait limit in cycles; used only when TXWREGIF_TIMEOUT_EN is defined; range 1..255.

Ports:
- clk  in  1  Single clock. Tie to the FIFO read clock.
- reset  in  1  Synchronous, active-high reset.
- fifo_rdempty  in  1  FIFO read-side empty flag.
- fifo_dataout  in  WIDTH  FIFO read data. Valid the cycle after fifo_rden.
- fifo_rdusedw  in  PTR+1  FIFO fill level. Observed only, routed to dbg_fill.
- fifo_rden  out  1  FIFO pop request.
- reg_wr  out  1  Register write request. Level; held until ack.
- reg_addr  out  16  Register address. Stable while reg_wr=1.
- reg_wdata  out  32  Register write data. Stable while reg_wr=1.
- reg_ack  in  1  Register file accept. Single-cycle pulse.
- wr_done  out  1  One-cycle pulse when a write completes.
- wr_cnt  out  16  Completed-write counter. Wraps.
- busy  out  1  High in any state other than IDLE.
- err  out  1  Timeout pulse. Tied 0 when the optional feature is off.
- dbg_fill  out  PTR+1  Registered copy of fifo_rdusedw.

Behaviour:
- Reset values: all outputs 0. State=IDLE, word counter wcnt=0, rd_pend=0.
- Reset taken mid-operation aborts the record. Partially captured words are discarded. FIFO contents are not touched, because the FIFO has its own reset.
- Record format (FIFO order):
  - word0 = reg_addr[15:0]
  - word1 = reg_wdata[31:16]
  - word2 = reg_wdata[15:0]
- States: IDLE, FETCH, WRITE.
- IDLE -> FETCH when fifo_rdempty=0. wcnt=0.
- FETCH:
  - fifo_rden = !fifo_rdempty && !rd_pend, combinational, FETCH only.
  - rd_pend<=fifo_rden.
  - When rd_pend=1, capture fifo_dataout into the slot selected by wcnt, then wcnt<=wcnt+1.
  - A capture with wcnt=2 moves the state to WRITE on the next edge.
  - Per-word cost is 2 cycles; minimum 6 cycles from leaving IDLE to WRITE.
  - An empty FIFO stalls FETCH indefinitely with no rden.
- WRITE:
  - reg_wr=1 (registered, asserted on WRITE entry). reg_addr/reg_wdata come from the capture registers.
  - On reg_ack=1: next cycle reg_wr=0, wr_done=1 for 1 cycle, wr_cnt<=wr_cnt+1 (0xFFFF wraps to 0x0000), state->IDLE.
  - An ack seen when reg_wr=0 is ignored.
- Back-to-back records: IDLE is visited for exactly 1 cycle between records. No rden is issued in IDLE or WRITE.
- fifo_rden never asserts while fifo_rdempty=1. No underflow is possible.
- dbg_fill <= fifo_rdusedw every cycle.

Optional Feature:
- Macro: TXWREGIF_TIMEOUT_EN.
- Defined:
  - An 8-bit ack-wait counter clears on WRITE entry and increments each WRITE cycle without ack.
  - When it reaches TIMEOUT: reg_wr<=0, err=1 for 1 cycle, state->IDLE. No wr_done and no wr_cnt increment.
  - An ack in the same cycle as the limit wins, and the write completes normally.
- Not defined: no counter; WRITE waits forever for ack; err tied 0.

Test Plan:
- Single record: push 0x0040, 0xDEAD, 0xBEEF; ack 2 cycles after reg_wr.
  -> reg_addr=0x0040, reg_wdata=0xDEADBEEF, exactly 3 rden pulses, wr_done pulse once, wr_cnt=1.
- Stalled FIFO: push 0x0010 only, wait 20 cycles, then push 0x1234, 0x5678.
  -> busy=1 throughout, no rden while empty, write addr 0x0010, data 0x12345678.
- Back-to-back: 4 records queued, ack immediately.
  -> 4 writes in order, 1 IDLE cycle between each, wr_cnt=4, no reg_wr overlap.
- Reset mid-record: assert reset after the 2nd word is captured.
  -> next cycle all outputs 0, state IDLE, wr_cnt=0, the next word popped is treated as word0.
- Counter wrap: preload 65535 writes (or force wr_cnt=0xFFFF), then one write.
  -> wr_cnt=0x0000, wr_done=1.
- Timeout (TXWREGIF_TIMEOUT_EN, TIMEOUT=8): never ack.
  -> reg_wr drops after 8 WRITE cycles, err pulse, wr_cnt unchanged.
  -> Repeat with ack on cycle 8: normal completion, err=0.
